// File: rtl/inst_sequencer.sv
// Programmable instruction sequencer for the PE control decoder.
// The host loads a small program while the block is idle. The block then
// issues one instruction per cycle and repeats the program for the
// programmed number of passes. A LOAD opcode waits for upstream data.
// After the final issue the block waits out the decoder write-back latency
// and then pulses done.
module inst_sequencer #(
  parameter int INST_WIDTH = 64,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int WB_LAT     = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  prog_we,
  input  logic [ADDR_W-1:0]     prog_addr,
  input  logic [INST_WIDTH-1:0] prog_data,
  input  logic [ADDR_W:0]       prog_len,
  input  logic [7:0]            loops,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  output logic                  inst_v,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            pass_cnt
);

  localparam int DW = $clog2(WB_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [ADDR_W:0]       len_q, len_d;
  logic [7:0]            loops_q, loops_d;
  logic [7:0]            pass_q, pass_d;
  logic [DW-1:0]         drain_q, drain_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  inst_v_q, inst_v_d;
  logic                  done_q, done_d;

  logic [INST_WIDTH-1:0] mem [DEPTH];
  logic [INST_WIDTH-1:0] cur;
  logic                  is_load, issue, last_inst, last_pass;

  assign busy      = (state_q != S_IDLE);
  assign cur       = mem[pc_q];
  assign is_load   = (cur[31:29] == 3'b000);
  // A LOAD issues only when upload data is present. Abort overrides any issue.
  assign issue     = (state_q == S_ISSUE) && !abort && (!is_load || ld_valid);
  assign ld_ready  = issue && is_load;
  assign last_inst = ({1'b0, pc_q} == (len_q - 1'b1));
  assign last_pass = (pass_q == (loops_q - 8'd1));

  assign inst_v   = inst_v_q;
  assign inst     = inst_q;
  assign done     = done_q;
  assign pass_cnt = pass_q;

  // Program memory is written only while idle. It has no reset.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) mem[prog_addr] <= prog_data;
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      loops_q  <= '0;
      pass_q   <= '0;
      drain_q  <= '0;
      inst_q   <= '0;
      inst_v_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      loops_q  <= loops_d;
      pass_q   <= pass_d;
      drain_q  <= drain_d;
      inst_q   <= inst_d;
      inst_v_q <= inst_v_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic. Abort is checked first and wins over start and issue.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    loops_d  = loops_q;
    pass_d   = pass_q;
    drain_d  = drain_q;
    inst_d   = inst_q;
    inst_v_d = 1'b0;
    done_d   = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (prog_len != '0) begin
              len_d   = prog_len;
              loops_d = (loops == 8'd0) ? 8'd1 : loops;
              pc_d    = '0;
              pass_d  = '0;
              state_d = S_ISSUE;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (issue) begin
            inst_v_d = 1'b1;
            inst_d   = cur;
            if (last_inst) begin
              if (last_pass) begin
                state_d = S_DRAIN;
                drain_d = DW'(WB_LAT);
              end else begin
                pc_d   = '0;
                pass_d = pass_q + 8'd1;
              end
            end else begin
              pc_d = pc_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          drain_d = drain_q - 1'b1;
          if (drain_q == DW'(1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// Bench for inst_sequencer. For each run it builds the expected issue
// timeline from the program, pass count and ld_valid pattern. It then
// checks every DUT output on every cycle against that timeline.
module tb_inst_sequencer;
  localparam int IW = 64;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int WB = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic [AW:0]   prog_len;
  logic [7:0]    loops;
  logic          start, abort, ld_valid;
  logic          ld_ready, inst_v, busy, done;
  logic [IW-1:0] inst;
  logic [7:0]    pass_cnt;

  int checks = 0;
  int errors = 0;
  logic [IW-1:0] mm [DEPTH];
  logic [IW-1:0] last_w;
  bit            lv [0:1023];

  always #5 clk = ~clk;

  inst_sequencer #(.INST_WIDTH(IW), .DEPTH(DEPTH), .ADDR_W(AW), .WB_LAT(WB)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .loops(loops), .start(start),
    .abort(abort), .ld_valid(ld_valid), .ld_ready(ld_ready), .inst_v(inst_v),
    .inst(inst), .busy(busy), .done(done), .pass_cnt(pass_cnt)
  );

  task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic [2:0] op);
    logic [IW-1:0] w;
    w = {$urandom, $urandom};
    w[31:29] = op;
    return w;
  endfunction

  task automatic wr(input int a, input logic [IW-1:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a[AW-1:0]; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
    mm[a] = d;
  endtask

  // mode: 0 ld_valid always 1, 1 random ld_valid, 2 ld_valid low for cycles 0..5.
  // ab_k: index of the issue whose decision cycle is aborted (-1 for none).
  // rst_off: assert reset this many cycles after the last issue (-1 for none).
  task automatic run(input int len, input int lp, input int mode, input int ab_k, input int rst_off);
    int ecyc[$];
    logic [IW-1:0] ewd[$];
    logic [IW-1:0] w;
    int eff, t, ab_c, done_c, last_c, end_c, busy_last, n, k, nd, pexp;
    logic exp_ldr;
    for (int c = 0; c < 1024; c++)
      lv[c] = (c >= 900) ? 1'b1 : (mode == 0) ? 1'b1 : (mode == 2) ? (c >= 6) : 1'($urandom_range(0, 1));
    eff = (lp == 0) ? 1 : lp;
    t = 0;
    // Each instruction is decided in cycle t and becomes visible in cycle t+1.
    // A LOAD waits until ld_valid is seen high.
    for (int p = 0; p < eff; p++)
      for (int i = 0; i < len; i++) begin
        w = mm[i];
        if (w[31:29] == 3'b000) while (!lv[t]) t++;
        ecyc.push_back(t + 1);
        ewd.push_back(w);
        t++;
      end
    ab_c = -1;
    if (ab_k >= 0) begin
      ab_c = ecyc[ab_k] - 1;
      while (ecyc.size() > ab_k) begin
        void'(ecyc.pop_back());
        void'(ewd.pop_back());
      end
    end
    n = ecyc.size();
    last_c = ecyc[n-1];
    done_c = (ab_c >= 0) ? -1 : last_c + WB;
    busy_last = (ab_c >= 0) ? ab_c : done_c;
    end_c = (rst_off >= 0) ? last_c + rst_off : (ab_c >= 0) ? ab_c + WB + 3 : done_c + 1;

    @(negedge clk);
    start = 1'b1; prog_len = len[AW:0]; loops = lp[7:0]; ld_valid = 1'b0; abort = 1'b0;
    k = 0;
    for (int c = 0; c <= end_c; c++) begin
      @(negedge clk);
      nd = 0;
      foreach (ecyc[j]) if (ecyc[j] <= c) nd++;
      pexp = nd / len;
      if (pexp > eff - 1) pexp = eff - 1;
      if (k < n && ecyc[k] == c) begin
        chk("inst_v", IW'(inst_v), IW'(1));
        chk("inst", inst, ewd[k]);
        last_w = ewd[k];
        k++;
      end else begin
        chk("inst_v", IW'(inst_v), IW'(0));
        chk("inst_hold", inst, last_w);
      end
      chk("busy", IW'(busy), IW'(c <= busy_last));
      chk("done", IW'(done), IW'(c == done_c));
      chk("pass_cnt", IW'(pass_cnt), IW'(pexp));
      if (c == end_c && rst_off >= 0) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", IW'(busy), IW'(0));
        chk("rst_inst_v", IW'(inst_v), IW'(0));
        chk("rst_done", IW'(done), IW'(0));
        chk("rst_pass", IW'(pass_cnt), IW'(0));
        chk("rst_inst", inst, IW'(0));
        start = 1'b0; prog_we = 1'b0; abort = 1'b0; ld_valid = 1'b0;
        #1 rst_n = 1'b1;
        last_w = '0;
      end else begin
        ld_valid  = lv[c];
        abort     = (c == ab_c);
        start     = (c <= busy_last) ? 1'($urandom_range(0, 1)) : 1'b0;
        prog_we   = (c <= busy_last);
        prog_addr = AW'($urandom);
        prog_data = {$urandom, $urandom};
        #1;
        exp_ldr = 1'b0;
        foreach (ecyc[j]) if (ecyc[j] == c + 1 && ewd[j][31:29] == 3'b000) exp_ldr = 1'b1;
        chk("ld_ready", IW'(ld_ready), IW'(exp_ldr));
      end
    end
    start = 1'b0; prog_we = 1'b0; abort = 1'b0;
  endtask

  initial begin
    logic [2:0] ops [4];
    int len, lp;
    ops[0] = 3'b001; ops[1] = 3'b010; ops[2] = 3'b100; ops[3] = 3'b101;
    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
    loops = '0; start = 1'b0; abort = 1'b0; ld_valid = 1'b0; last_w = '0;
    #1;
    chk("reset_busy", IW'(busy), IW'(0));
    chk("reset_inst_v", IW'(inst_v), IW'(0));
    chk("reset_inst", inst, IW'(0));
    chk("reset_done", IW'(done), IW'(0));
    chk("reset_ld_ready", IW'(ld_ready), IW'(0));
    chk("reset_pass", IW'(pass_cnt), IW'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Sequential program with four compute opcodes.
    for (int i = 0; i < 4; i++) wr(i, mk(ops[i]));
    run(4, 1, 0, -1, -1);

    // LOAD stall on the second instruction.
    wr(0, mk(3'b011)); wr(1, mk(3'b000)); wr(2, mk(3'b110));
    run(3, 1, 2, -1, -1);

    // Multiple passes with no bubble between passes.
    wr(0, mk(3'b111)); wr(1, mk(3'b001));
    run(2, 3, 0, -1, -1);

    // Full-depth program, with loops=0 treated as one pass.
    for (int i = 0; i < DEPTH; i++) wr(i, mk(3'($urandom_range(1, 7))));
    run(16, 0, 0, -1, -1);
    for (int i = 0; i < DEPTH; i++) wr(i, mk(3'($urandom_range(0, 7))));
    run(16, 2, 1, -1, -1);

    // Zero-length program: done on the next cycle with busy never high.
    @(negedge clk);
    start = 1'b1; prog_len = '0; loops = 8'd3;
    @(negedge clk);
    start = 1'b0;
    chk("len0_done", IW'(done), IW'(1));
    chk("len0_busy", IW'(busy), IW'(0));
    @(negedge clk);
    chk("len0_done_end", IW'(done), IW'(0));
    chk("len0_busy_end", IW'(busy), IW'(0));

    // Abort on the third issue, then run the program again from pc 0.
    for (int i = 0; i < 10; i++) wr(i, mk(3'($urandom_range(1, 7))));
    run(10, 1, 0, 2, -1);
    run(10, 1, 0, -1, -1);

    // Asynchronous reset in the middle of DRAIN, then confirm that the
    // memory is unchanged after the prog_we strobes driven while busy.
    run(4, 2, 0, -1, 2);
    run(4, 1, 1, -1, -1);

    // Randomised programs, some with LOADs.
    for (int r = 0; r < 3; r++) begin
      len = $urandom_range(1, 16);
      lp  = $urandom_range(0, 3);
      for (int i = 0; i < len; i++) wr(i, mk(3'($urandom_range(0, 7))));
      run(len, lp, 1, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
